// File: rtl/photonic_pkg.sv
// Shared constants and state encoding for the photonic switch word sequencer.
package photonic_pkg;

    localparam int WW    = 13;             // switch word width
    localparam int DEPTH = 8;              // word table entries (power of 2)
    localparam int DWW   = 16;             // dwell counter width
    localparam int AW    = $clog2(DEPTH);  // table address / index width
    localparam int LW    = AW + 1;         // sequence length width (0..DEPTH)

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PULSE,
        DWELL,
        FINISH
    } seq_state_t;

endpackage

// File: rtl/switch_word_sequencer_dwell_timer.sv
// Loadable down-counter shared by the sequencer for both the reset-pulse
// length and the per-word dwell. Stops at zero; zero flag is combinational.
module dwell_timer
    import photonic_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           load,
    input  logic [DWW-1:0] load_val,
    output logic           zero
);

    logic [DWW-1:0] cnt_q;
    logic [DWW-1:0] cnt_d;

    // Next count: load has priority, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DWW'(1);
        end
    end

    // Count register; clock enable freezes the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/switch_word_sequencer.sv
// Plays a programmed table of switch words into the photonic switch top:
// for each word it loads W, pulses sw_reset for RST_CYCLES, then dwells.
// Optional build macro SEQ_LOOP_EN: repeat the table forever (done pulses
// once per pass) instead of a single pass ending in FINISH.
module switch_word_sequencer
    import photonic_pkg::*;
#(
    parameter int RST_CYCLES = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [WW-1:0]  wr_data,
    input  logic [LW-1:0]  len,
    input  logic [DWW-1:0] dwell,
    input  logic           start,
    input  logic           abort,
    output logic [WW-1:0]  sw_W,
    output logic           sw_reset,
    output logic           sw_load,
    output logic           busy,
    output logic           done,
    output logic [AW-1:0]  idx
);

    seq_state_t     state_q, state_d;
    logic [WW-1:0]  sw_w_q, sw_w_d;
    logic           sw_reset_q, sw_reset_d;
    logic           sw_load_q, sw_load_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [LW-1:0]  len_q, len_d;
    logic [DWW-1:0] dwell_q, dwell_d;

    logic           tmr_load;
    logic [DWW-1:0] tmr_val;
    logic           tmr_zero;
    logic           last_word;

    logic [WW-1:0]  tbl_q [DEPTH];

    // Word table: written any time the block is enabled; no reset on contents.
    always_ff @(posedge clk) begin
        if (en && wr_en) begin
            tbl_q[wr_addr] <= wr_data;
        end
    end

    dwell_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign last_word = ({1'b0, idx_q} == (len_q - LW'(1)));

    // Next-state and registered-output logic; abort overrides every state.
    always_comb begin
        state_d    = state_q;
        sw_w_d     = sw_w_q;
        sw_reset_d = sw_reset_q;
        sw_load_d  = sw_load_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        idx_d      = idx_q;
        len_d      = len_q;
        dwell_d    = dwell_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        if (abort) begin
            state_d    = IDLE;
            sw_reset_d = 1'b1;
            sw_load_d  = 1'b0;
            busy_d     = 1'b0;
            idx_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            // Empty sequence completes immediately.
                            done_d = 1'b1;
                        end else begin
                            state_d    = FETCH;
                            busy_d     = 1'b1;
                            idx_d      = '0;
                            len_d      = len;
                            dwell_d    = (dwell == '0) ? DWW'(1) : dwell;
                            sw_reset_d = 1'b0;
                        end
                    end
                end
                FETCH: begin
                    sw_w_d     = tbl_q[idx_q];
                    state_d    = PULSE;
                    sw_reset_d = 1'b1;
                    sw_load_d  = (idx_q == '0);
                    tmr_load   = 1'b1;
                    tmr_val    = DWW'(RST_CYCLES - 1);
                end
                PULSE: begin
                    if (tmr_zero) begin
                        state_d    = DWELL;
                        sw_reset_d = 1'b0;
                        sw_load_d  = 1'b0;
                        tmr_load   = 1'b1;
                        tmr_val    = dwell_q - DWW'(1);
                    end
                end
                DWELL: begin
                    if (tmr_zero) begin
                        if (last_word) begin
`ifdef SEQ_LOOP_EN
                            state_d = FETCH;
                            idx_d   = '0;
                            done_d  = 1'b1;
`else
                            state_d = FINISH;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
`endif
                        end else begin
                            state_d = FETCH;
                            idx_d   = idx_q + AW'(1);
                        end
                    end
                end
                FINISH: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Sequencer state and output registers; en low freezes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sw_w_q     <= '0;
            sw_reset_q <= 1'b1;
            sw_load_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            idx_q      <= '0;
            len_q      <= '0;
            dwell_q    <= DWW'(1);
        end else if (en) begin
            state_q    <= state_d;
            sw_w_q     <= sw_w_d;
            sw_reset_q <= sw_reset_d;
            sw_load_q  <= sw_load_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            dwell_q    <= dwell_d;
        end
    end

    assign sw_W     = sw_w_q;
    assign sw_reset = sw_reset_q;
    assign sw_load  = sw_load_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign idx      = idx_q;

endmodule

// File: tb/tb_switch_word_sequencer.sv
// Directed bench for switch_word_sequencer. Cycle k counts edges after the
// edge that samples start: FETCH at k=0, word w occupies k in [w*P, (w+1)*P).
module tb_switch_word_sequencer;
    import photonic_pkg::*;

    logic           clk;
    logic           reset;
    logic           en;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [WW-1:0]  wr_data;
    logic [LW-1:0]  len;
    logic [DWW-1:0] dwell;
    logic           start;
    logic           abort;
    logic [WW-1:0]  sw_W;
    logic           sw_reset;
    logic           sw_load;
    logic           busy;
    logic           done;
    logic [AW-1:0]  idx;

    int checks;
    int failures;

    logic [WW-1:0] model_tbl [DEPTH];

    switch_word_sequencer #(.RST_CYCLES(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .len      (len),
        .dwell    (dwell),
        .start    (start),
        .abort    (abort),
        .sw_W     (sw_W),
        .sw_reset (sw_reset),
        .sw_load  (sw_load),
        .busy     (busy),
        .done     (done),
        .idx      (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tbl(input int a, input logic [WW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        model_tbl[a] = d;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_sw_reset"}, sw_reset, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_idx"}, idx, 0);
        chk({tag, "_sw_load"}, sw_load, 0);
    endtask

    // Expected outputs at cycle k of a single pass of n words, period p.
    task automatic expect_at(input int k, input int p, input int n,
                             input logic [WW-1:0] w_prev, input string tag);
        int w;
        int ph;
        logic [WW-1:0] ew;
        w  = k / p;
        ph = k % p;
        if (k >= n * p) begin
            chk($sformatf("%s_done_k%0d", tag, k), done, 1);
            chk($sformatf("%s_busy_k%0d", tag, k), busy, 0);
            chk($sformatf("%s_swrst_k%0d", tag, k), sw_reset, 0);
            chk($sformatf("%s_swW_k%0d", tag, k), sw_W, model_tbl[n-1]);
            chk($sformatf("%s_idx_k%0d", tag, k), idx, n - 1);
        end else begin
            if (ph == 0) ew = (w == 0) ? w_prev : model_tbl[w-1];
            else         ew = model_tbl[w];
            chk($sformatf("%s_done_k%0d", tag, k), done, 0);
            chk($sformatf("%s_busy_k%0d", tag, k), busy, 1);
            chk($sformatf("%s_idx_k%0d", tag, k), idx, w);
            chk($sformatf("%s_swrst_k%0d", tag, k), sw_reset, (ph >= 1 && ph <= 3) ? 1 : 0);
            chk($sformatf("%s_swload_k%0d", tag, k), sw_load, (ph >= 1 && ph <= 3 && w == 0) ? 1 : 0);
            chk($sformatf("%s_swW_k%0d", tag, k), sw_W, ew);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        en       = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        len      = '0;
        dwell    = '0;
        start    = 1'b0;
        abort    = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_tbl[i] = '0;

        // T1: reset holds the switch in reset with a cleared word
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle_reset($sformatf("t1_c%0d", i));
            chk($sformatf("t1_swW_c%0d", i), sw_W, 0);
        end
        reset = 1'b0;
        tick();
        chk_idle_reset("t1_post");

        // Empty sequence: done pulse, stays idle
        len   = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_swrst", sw_reset, 1);
        tick();
        chk("len0_done_clr", done, 0);

`ifdef SEQ_LOOP_EN
        // T6: looping two words, dwell 4 -> 8-cycle words, 16-cycle passes
        write_tbl(0, 13'd2);
        write_tbl(1, 13'd6401);
        len   = LW'(2);
        dwell = DWW'(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            int w;
            int ph;
            logic [WW-1:0] ew;
            w  = (k / 8) % 2;
            ph = k % 8;
            if (ph == 0) ew = (k == 0) ? 13'd0 : model_tbl[1-w];
            else         ew = model_tbl[w];
            chk($sformatf("t6_done_k%0d", k), done, (k > 0 && k % 16 == 0) ? 1 : 0);
            chk($sformatf("t6_busy_k%0d", k), busy, 1);
            chk($sformatf("t6_idx_k%0d", k), idx, w);
            chk($sformatf("t6_swrst_k%0d", k), sw_reset, (ph >= 1 && ph <= 3) ? 1 : 0);
            chk($sformatf("t6_swW_k%0d", k), sw_W, ew);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle_reset("t6_abort");
`else
        // T2: three words, dwell 10 -> 14-cycle words, done at k=42
        write_tbl(0, 13'd2);
        write_tbl(1, 13'd6401);
        write_tbl(2, 13'd3000);
        len   = LW'(3);
        dwell = DWW'(10);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 42; k++) begin
            expect_at(k, 14, 3, 13'd0, "t2");
            start = (k == 20);              // start while busy is ignored
            if (k == 5) begin               // len/dwell changes mid-run ignored
                len   = LW'(1);
                dwell = DWW'(2);
            end
            if (k < 42) tick();
        end
        start = 1'b0;
        tick();
        chk("t2_done_clr", done, 0);
        chk("t2_busy_idle", busy, 0);
        chk("t2_swW_hold", sw_W, 3000);
        chk("t2_swrst_idle", sw_reset, 0);

        // T3: dwell 0 acts as 1 -> done at k=5
        write_tbl(0, 13'd5);
        len   = LW'(1);
        dwell = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            expect_at(k, 5, 1, 13'd3000, "t3");
            if (k < 5) tick();
        end

        // T4: abort during the dwell of word 1
        tick();
        len   = LW'(3);
        dwell = DWW'(10);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 19; k++) begin
            expect_at(k, 14, 3, 13'd5, "t4");
            if (k < 19) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle_reset("t4_abort");
        chk("t4_swW_hold", sw_W, 6401);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_idle_reset($sformatf("t4_idle_c%0d", i));
        end
        // abort wins over a simultaneous start
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk_idle_reset("t4_abort_start");

        // T5: restart from idx 0; en low 7 cycles in PULSE stretches the run by 7;
        // mid-run table writes only affect later fetches
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 42; k++) begin
            expect_at(k, 14, 3, 13'd6401, "t5");
            if (k == 6) begin
                wr_en = 1'b1; wr_addr = AW'(0); wr_data = 13'd77;
            end else if (k == 28) begin
                wr_en = 1'b1; wr_addr = AW'(2); wr_data = 13'd99;
            end else begin
                wr_en = 1'b0;
            end
            if (k == 2) begin
                en = 1'b0;
                for (int f = 0; f < 7; f++) begin
                    tick();
                    expect_at(2, 14, 3, 13'd6401, $sformatf("t5_frz%0d", f));
                end
                en = 1'b1;
            end
            if (k < 42) tick();
        end
        wr_en = 1'b0;
        model_tbl[0] = 13'd77;
        model_tbl[2] = 13'd99;

        // Async reset mid-run returns outputs to reset values without a clock edge
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_mid_pre_busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        chk_idle_reset("rst_mid");
        chk("rst_mid_swW", sw_W, 0);
        tick();
        reset = 1'b0;
        tick();
        chk_idle_reset("rst_mid_post");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
